// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to packed BCD converter.
// Also emits a leading-zero mask for blanking the high display digits.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     lz_mask
);

  localparam int BW = 4 * DIGITS;
  localparam int TW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] LZ_RST =
    {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [TW-1:0]   sr;
  logic [TW-1:0]   sr_adj;
  logic [CW-1:0]   cnt;
  logic [DIGITS-1:0] lz_nx;
  logic            zrun;
  logic            last;

  assign last = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and busy decode
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nx = FINISH;
      end
      FINISH: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Add 3 to every BCD nibble that is 5 or more
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[WIDTH+4*i +: 4] >= 4'd5)
        sr_adj[WIDTH+4*i +: 4] =
          sr[WIDTH+4*i +: 4] + 4'd3;
    end
  end

  // Leading-zero mask from the finished BCD field
  always_comb begin
    lz_nx = '0;
    zrun  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zrun     = zrun & (sr[WIDTH+4*i +: 4] == 4'd0);
      lz_nx[i] = zrun;
    end
  end

  // Shift register, counter and registered results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr      <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      bcd_out <= '0;
      lz_mask <= LZ_RST;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sr  <= {{BW{1'b0}}, bin_in};
            cnt <= '0;
          end
        end
        SHIFT: begin
          sr  <= sr_adj << 1;
          cnt <= cnt + CW'(1);
        end
        FINISH: begin
          bcd_out <= sr[TW-1:WIDTH];
          lz_mask <= lz_nx;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq.
// Decimal reference is computed with / and % in the bench.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic [2:0]  lz_mask;

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;
  logic [14:0] q[$];

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .lz_mask (lz_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [11:0] ref_bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] ref_lz(int v);
    return {(v < 100), (v < 10), 1'b0};
  endfunction

  task automatic start_conv(input int v, input bit push);
    bin_in = 8'(v);
    start  = 1'b1;
    if (push) q.push_back({ref_lz(v), ref_bcd(v)});
  endtask

  task automatic wait_done(
    input  int poke_lat, input int poke_val,
    output bit got, output int lat, output int bsy,
    output bit stable, output int at);
    logic [11:0] b0;
    got = 0; lat = 0; bsy = 0; stable = 1; at = 0;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 8'($urandom);
    b0     = bcd_out;
    while (lat < 20) begin
      if (done) begin
        got = 1;
        at  = cyc;
        break;
      end
      if (busy) bsy++;
      if (bcd_out !== b0) stable = 0;
      if (lat == poke_lat) begin
        start  = 1'b1;
        bin_in = 8'(poke_val);
      end else if (lat == poke_lat + 1) begin
        start  = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) c++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; bin_in = '0;
    repeat (3) @(negedge clk);
    ncmp += 4;
    if (busy !== 1'b0) begin
      nerr++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    if (done !== 1'b0) begin
      nerr++; $display("FAIL rst_done: got %b want 0", done);
    end
    if (bcd_out !== 12'h000) begin
      nerr++; $display("FAIL rst_bcd: got %h want 000", bcd_out);
    end
    if (lz_mask !== 3'b110) begin
      nerr++; $display("FAIL rst_lz: got %b want 110", lz_mask);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int vals[5] = '{0, 255, 7, 100, 42};
    bit g, st; int lat, bsy, at;
    logic [14:0] e;
    foreach (vals[i]) begin
      start_conv(vals[i], 1);
      wait_done(-5, 0, g, lat, bsy, st, at);
      e = q.pop_front();
      ncmp += 7;
      if (!g) begin
        nerr++; $display("FAIL basic_done v=%0d: got none want pulse", vals[i]);
      end
      if (lat !== 9) begin
        nerr++; $display("FAIL basic_lat v=%0d: got %0d want 9", vals[i], lat);
      end
      if (bsy !== 9) begin
        nerr++; $display("FAIL basic_busy v=%0d: got %0d want 9", vals[i], bsy);
      end
      if (!st) begin
        nerr++; $display("FAIL basic_hold v=%0d: got changing want stable", vals[i]);
      end
      if (bcd_out !== e[11:0]) begin
        nerr++; $display("FAIL basic_bcd v=%0d: got %h want %h", vals[i], bcd_out, e[11:0]);
      end
      if (lz_mask !== e[14:12]) begin
        nerr++; $display("FAIL basic_lz v=%0d: got %b want %b", vals[i], lz_mask, e[14:12]);
      end
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) begin
        nerr++; $display("FAIL basic_pulse v=%0d: got done=%b busy=%b want 0 0", vals[i], done, busy);
      end
    end
  endtask

  task automatic test_ignore;
    bit g, st; int lat, bsy, at, c;
    logic [14:0] e;
    start_conv(99, 1);
    wait_done(2, 200, g, lat, bsy, st, at);
    e = q.pop_front();
    count_done(15, c);
    ncmp += 4;
    if (!g || lat !== 9) begin
      nerr++; $display("FAIL ign_lat: got %0d want 9", lat);
    end
    if (bcd_out !== e[11:0]) begin
      nerr++; $display("FAIL ign_bcd: got %h want %h", bcd_out, e[11:0]);
    end
    if (lz_mask !== e[14:12]) begin
      nerr++; $display("FAIL ign_lz: got %b want %b", lz_mask, e[14:12]);
    end
    if (c !== 0) begin
      nerr++; $display("FAIL ign_extra: got %0d want 0", c);
    end
  endtask

  task automatic test_back_to_back;
    bit g1, g2, st; int lat, bsy, at1, at2;
    logic [14:0] e;
    start_conv(19, 1);
    wait_done(-5, 0, g1, lat, bsy, st, at1);
    e = q.pop_front();
    ncmp += 1;
    if (!g1 || bcd_out !== e[11:0]) begin
      nerr++; $display("FAIL b2b_first: got %h want %h", bcd_out, e[11:0]);
    end
    start_conv(250, 1);
    wait_done(-5, 0, g2, lat, bsy, st, at2);
    e = q.pop_front();
    ncmp += 3;
    if (!g2 || (at2 - at1) !== 10) begin
      nerr++; $display("FAIL b2b_gap: got %0d want 10", at2 - at1);
    end
    if (bcd_out !== e[11:0]) begin
      nerr++; $display("FAIL b2b_second: got %h want %h", bcd_out, e[11:0]);
    end
    if (lz_mask !== e[14:12]) begin
      nerr++; $display("FAIL b2b_lz: got %b want %b", lz_mask, e[14:12]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    bit g, st; int lat, bsy, at, c;
    logic [14:0] e;
    start_conv(123, 0);
    @(negedge clk);
    start  = 1'b0;
    bin_in = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    ncmp += 3;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL abort_ctl: got busy=%b done=%b want 0 0", busy, done);
    end
    if (bcd_out !== 12'h000) begin
      nerr++; $display("FAIL abort_bcd: got %h want 000", bcd_out);
    end
    if (lz_mask !== 3'b110) begin
      nerr++; $display("FAIL abort_lz: got %b want 110", lz_mask);
    end
    rst_n = 1'b1;
    count_done(15, c);
    ncmp += 1;
    if (c !== 0) begin
      nerr++; $display("FAIL abort_done: got %0d want 0", c);
    end
    start_conv(56, 1);
    wait_done(-5, 0, g, lat, bsy, st, at);
    e = q.pop_front();
    ncmp += 2;
    if (!g || lat !== 9) begin
      nerr++; $display("FAIL post_lat: got %0d want 9", lat);
    end
    if (bcd_out !== e[11:0] || lz_mask !== e[14:12]) begin
      nerr++; $display("FAIL post_val: got %h/%b want %h/%b", bcd_out, lz_mask, e[11:0], e[14:12]);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep;
    bit g, st, ok9; int lat, bsy, at;
    logic [14:0] e;
    for (int v = 0; v < 256; v++) begin
      start_conv(v, 1);
      wait_done(-5, 0, g, lat, bsy, st, at);
      e = q.pop_front();
      ok9 = 1;
      for (int d = 0; d < 3; d++)
        if (bcd_out[4*d +: 4] > 4'd9) ok9 = 0;
      ncmp += 3;
      if (!g || bcd_out !== e[11:0]) begin
        nerr++; $display("FAIL sweep_bcd v=%0d: got %h want %h", v, bcd_out, e[11:0]);
      end
      if (lz_mask !== e[14:12]) begin
        nerr++; $display("FAIL sweep_lz v=%0d: got %b want %b", v, lz_mask, e[14:12]);
      end
      if (!ok9) begin
        nerr++; $display("FAIL sweep_digit v=%0d: got %h want nibbles<=9", v, bcd_out);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL queue_left: got %0d want 0", q.size());
    end
    ncmp++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
